// File: rtl/top_uart_pkg.sv
// Shared UART definitions: framing constants, store depth, state encoding.
// Also provides the baud divider, rounded to the nearest clock.
package top_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MEM_DEPTH = 32;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle done_o pulse.
// Cannot be stalled; a framing error drops the byte and waits for the line to return high.
module uart_rx
  import top_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 579
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 done_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Half-bit recheck rejects glitches and aligns later samples to mid-bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (ferr_q) begin
          if (rx_s) state_d = ST_IDLE;
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_o = shift_q;
  assign done_o = done_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter, each bit held CLKS_PER_BIT clocks; the first bit leaves one cycle after start_i.
// start_i is ignored while busy_o is high; the serial line is driven straight from a flop.
module uart_tx
  import top_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 579
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (start_i) begin
          shift_d = data_i;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/top_uart.sv
// UART byte logger: received bytes fill a 32-entry ring store and are echoed on Tx when it is free.
// data_LED shows mem[addr_RAM] one clock later; no flow control, so an echo is dropped if Tx is busy.
module top_uart
  import top_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 66_666_667,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  input  logic [ADDR_W-1:0]    addr_RAM,
  output logic                 Tx,
  output logic [DATA_BITS-1:0] data_LED
);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_done;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] mem_q [MEM_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DATA_BITS-1:0] led_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i  (clk),
    .rst_i  (rst),
    .rx_i   (Rx),
    .data_o (rx_byte),
    .done_o (rx_done)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (rx_done & ~tx_busy),
    .data_i  (rx_byte),
    .tx_o    (Tx),
    .busy_o  (tx_busy)
  );

  // Pointer wraps naturally at the store depth, overwriting the oldest byte.
  assign wr_ptr_d = rx_done ? wr_ptr_q + 1'b1 : wr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      led_q    <= '0;
    end else begin
      led_q    <= mem_q[addr_RAM];
      wr_ptr_q <= wr_ptr_d;
      if (rx_done) mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  assign data_LED = led_q;

endmodule

// File: tb/tb_top_uart.sv
// Bench for top_uart: random and fixed frames on Rx, checked against a ring-store model and an echo queue.
// Runs with a short bit period so the whole sequence stays small.
module tb_top_uart;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rx  = 1'b1;
  logic [4:0] addr_RAM = '0;
  logic       Tx;
  logic [7:0] data_LED;

  top_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .Rx       (Rx),
    .addr_RAM (addr_RAM),
    .Tx       (Tx),
    .data_LED (data_LED)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] mem_m [32];
  int         wp_m;
  logic [7:0] exp_tx [$];
  bit         tx_chk_en = 1'b1;
  logic [7:0] v17 [17] = '{8'h0A, 8'h0F, 8'h19, 8'h1F, 8'h2D, 8'h40, 8'h63, 8'h7F, 8'h9B,
                           8'hFF, 8'hBE, 8'h54, 8'h37, 8'h20, 8'h14, 8'h07, 8'h01};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
    wp_m = 0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial frame: start, 8 data bits LSB first, stop (optionally broken), then idle gap.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap_bits, input bit echo);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      Rx = fr[i];
      wait_clks(CPB);
    end
    Rx = 1'b1;
    if (stop_ok) begin
      mem_m[wp_m] = b;
      wp_m = (wp_m + 1) % 32;
      if (echo) exp_tx.push_back(b);
    end
    if (gap_bits > 0) wait_clks(gap_bits * CPB);
  endtask

  task automatic read_chk(input int a, input string tag);
    addr_RAM = 5'(a);
    wait_clks(2);
    check(tag, data_LED, mem_m[a]);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) read_chk(a, tag);
  endtask

  // Tx monitor: captures every frame one sample per clock from the first low sample.
  initial begin : tx_mon
    logic [10*CPB-1:0] smp;
    logic [7:0]        got, e;
    logic [9:0]        fr_e;
    int                errs;
    forever begin
      @(negedge clk);
      if (Tx === 1'b0) begin
        smp[0] = Tx;
        for (int k = 1; k < 10 * CPB; k++) begin
          @(negedge clk);
          smp[k] = Tx;
        end
        for (int b = 0; b < 8; b++) got[b] = smp[(b + 1) * CPB + CPB / 2];
        if (tx_chk_en) begin
          e    = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
          fr_e = {1'b1, e, 1'b0};
          errs = 0;
          for (int b = 0; b < 10; b++)
            if (smp[b * CPB + 1] !== fr_e[b] || smp[b * CPB + CPB - 2] !== fr_e[b]) errs++;
          check("tx_echo_byte", got, e);
          check("tx_bit_width", errs, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] rb;
    logic [7:0] a05 [6];
    logic [7:0] a5;
    a05 = '{8'h0A, 8'h0F, 8'h19, 8'h1F, 8'h2D, 8'h40};
    a5  = 8'hA5;
    model_reset();

    wait_clks(3);
    check("rst_tx_high", Tx, 1);
    check("rst_led_zero", data_LED, 0);
    rst = 1'b0;
    wait_clks(4);
    read_all("reset_mem");
    check("idle_tx_high", Tx, 1);

    foreach (v17[i]) send_frame(v17[i], 1'b1, 15, 1'b1);
    read_all("seq17_mem");
    for (int a = 0; a < 6; a++) begin
      addr_RAM = 5'(a);
      wait_clks(2);
      check("seq17_addr0_5", data_LED, a05[a]);
    end
    addr_RAM = 5'd8;  wait_clks(2); check("seq17_addr8", data_LED, 8'h9B);
    addr_RAM = 5'd16; wait_clks(2); check("seq17_addr16", data_LED, 8'h01);
    addr_RAM = 5'd17; wait_clks(2); check("seq17_addr17", data_LED, 8'h00);

    // Short glitch, then a frame with a broken stop bit; neither may be stored.
    Rx = 1'b0;
    wait_clks(3);
    Rx = 1'b1;
    wait_clks(3 * CPB);
    send_frame(8'h55, 1'b0, 3, 1'b1);
    rb = 8'($urandom);
    send_frame(rb, 1'b1, 15, 1'b1);
    addr_RAM = 5'd17; wait_clks(2); check("glitch_next_slot", data_LED, rb);
    read_chk(18, "glitch_no_extra");

    for (int i = 0; i < 6; i++) send_frame(8'($urandom), 1'b1, $urandom_range(12, 15), 1'b1);
    read_all("random_mem");

    // Back-to-back frames through a wrap; echoes are partly dropped here, so Tx is not scored.
    tx_chk_en = 1'b0;
    rst = 1'b1;
    model_reset();
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    for (int i = 0; i < 33; i++) send_frame(8'(i), 1'b1, 0, 1'b0);
    wait_clks(20 * CPB);
    read_all("wrap_mem");
    addr_RAM = 5'd0; wait_clks(2); check("wrap_addr0", data_LED, 8'h20);
    addr_RAM = 5'd1; wait_clks(2); check("wrap_addr1", data_LED, 8'h01);
    tx_chk_en = 1'b1;

    // Reset in the middle of 0xA5, then a clean 0x3C.
    Rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      Rx = a5[i];
      wait_clks(CPB);
    end
    Rx = a5[4];
    wait_clks(CPB / 2);
    rst = 1'b1;
    model_reset();
    Rx = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2 * CPB);
    send_frame(8'h3C, 1'b1, 15, 1'b1);
    addr_RAM = 5'd0; wait_clks(2); check("midrst_addr0", data_LED, 8'h3C);
    addr_RAM = 5'd1; wait_clks(2); check("midrst_addr1", data_LED, 8'h00);
    read_all("midrst_mem");

    wait_clks(2 * CPB);
    check("tx_pending_echoes", exp_tx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
